cmd_cfg_mc: RTL and testbench

// Parametrised command decoder/config block between the UART command wrapper and flight control.

---
 rtl/cmd_cfg_pkg.sv | 25 ++
 rtl/cmd_cfg_tmr.sv | 19 +
 rtl/cmd_cfg_mc.sv | 128 ++++++++++++
 tb/tb_cmd_cfg_mc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared opcodes, response codes and FSM state type for the command/config block.
// Opcodes above the setpoint range shift with NUM_SP so the setpoint opcodes stay contiguous.
package cmd_cfg_pkg;
  localparam logic [7:0] SP_BASE = 8'h02;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] NACK    = 8'hEE;

  typedef enum logic [1:0] {IDLE, CAL_WAIT, CAL_CHK, LAND} state_t;

  function automatic logic [7:0] op_thrst(input int num_sp);
    return 8'(32'h05 + num_sp - 3);
  endfunction

  function automatic logic [7:0] op_cal(input int num_sp);
    return 8'(32'h06 + num_sp - 3);
  endfunction

  function automatic logic [7:0] op_emer(input int num_sp);
    return 8'(32'h07 + num_sp - 3);
  endfunction

  function automatic logic [7:0] op_moff(input int num_sp);
    return 8'(32'h08 + num_sp - 3);
  endfunction
endpackage

// File: rtl/cmd_cfg_tmr.sv
// Shared settle/timeout/ramp counter; clear wins over increment, full at all-ones.
module cmd_cfg_tmr #(
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic full
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst)
    if (rst)     count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;

  assign full = &count;
endmodule

// File: rtl/cmd_cfg_mc.sv
// Command decoder/config: setpoint + thrust latches, calibration sequencing,
// ramped emergency landing and ACK/NACK responses for every consumed command.
module cmd_cfg_mc
  import cmd_cfg_pkg::*;
#(
  parameter int NUM_SP    = 3,
  parameter int SP_W      = 16,
  parameter int THR_W     = 9,
  parameter int FAST_SIM  = 0,
  parameter int RAMP_STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_rdy,
  input  logic [7:0]               cmd,
  input  logic [15:0]              data,
  input  logic                     cal_done,
  output logic                     clr_cmd_rdy,
  output logic                     send_resp,
  output logic [7:0]               resp,
  output logic [NUM_SP*SP_W-1:0]   sp,
  output logic [THR_W-1:0]         thrst,
  output logic                     strt_cal,
  output logic                     inertial_cal,
  output logic                     motors_off,
  output logic                     busy
);
  localparam int TMR_W = (FAST_SIM != 0) ? 9 : 26;
  localparam logic [7:0] OP_THR  = op_thrst(NUM_SP);
  localparam logic [7:0] OP_CAL  = op_cal(NUM_SP);
  localparam logic [7:0] OP_EMER = op_emer(NUM_SP);
  localparam logic [7:0] OP_MOFF = op_moff(NUM_SP);
  localparam logic [THR_W-1:0] STEP = THR_W'(RAMP_STEP);

  state_t state, nxt;
  logic [NUM_SP-1:0] sp_hit;
  logic sp_go, sp_zero, thr_wr, thr_ramp, thr_zero, mo_set, mo_clr, cal_go;
  logic rsp_vld, tmr_clr, tmr_en, tmr_full;
  logic [7:0] rsp_val;

  cmd_cfg_tmr #(.W(TMR_W)) u_tmr (
    .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .full(tmr_full)
  );

  always_comb begin
    nxt = state; clr_cmd_rdy = 1'b0; rsp_vld = 1'b0; rsp_val = ACK;
    tmr_clr = 1'b0; tmr_en = 1'b0; sp_go = 1'b0; sp_zero = 1'b0;
    thr_wr = 1'b0; thr_ramp = 1'b0; thr_zero = 1'b0;
    mo_set = 1'b0; mo_clr = 1'b0; cal_go = 1'b0;
    unique case (state)
      IDLE: if (cmd_rdy) begin
        clr_cmd_rdy = 1'b1;
        rsp_vld     = 1'b1;
        if (|sp_hit)              sp_go = 1'b1;
        else if (cmd == OP_THR)   thr_wr = 1'b1;
        else if (cmd == OP_MOFF)  mo_set = 1'b1;
        else if (cmd == OP_CAL) begin
          rsp_vld = 1'b0; cal_go = 1'b1; tmr_clr = 1'b1; nxt = CAL_WAIT;
        end else if (cmd == OP_EMER) begin
          sp_zero = 1'b1; tmr_clr = 1'b1; nxt = LAND;
        end else rsp_val = NACK;
      end
      CAL_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_full) begin tmr_clr = 1'b1; nxt = CAL_CHK; end
      end
      CAL_CHK: begin
        tmr_en = 1'b1;
        if (cal_done) begin
          mo_clr = 1'b1; rsp_vld = 1'b1; nxt = IDLE;
        end else if (tmr_full) begin
          rsp_vld = 1'b1; rsp_val = NACK; nxt = IDLE;
        end
      end
      LAND: begin
        tmr_en = 1'b1;
        if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          rsp_vld     = 1'b1;
          if (cmd == OP_MOFF) begin
            thr_zero = 1'b1; mo_set = 1'b1; nxt = IDLE;
          end else rsp_val = NACK;
        end
        // An explicit motors-off in the same cycle pre-empts the ramp tick
        if (tmr_full && !(cmd_rdy && cmd == OP_MOFF)) begin
          if (thrst == '0) begin mo_set = 1'b1; nxt = IDLE; end
          else thr_ramp = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_SP; i++) begin : g_sp
    logic [SP_W-1:0] q;
    assign sp_hit[i] = (cmd == 8'(SP_BASE + i));
    always_ff @(posedge clk or posedge rst)
      if (rst)                     q <= '0;
      else if (sp_zero)            q <= '0;
      else if (sp_go && sp_hit[i]) q <= data[SP_W-1:0];
    assign sp[i*SP_W +: SP_W] = q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)           thrst <= '0;
    else if (thr_zero) thrst <= '0;
    else if (thr_wr)   thrst <= data[THR_W-1:0];
    else if (thr_ramp) thrst <= (thrst > STEP) ? thrst - STEP : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      motors_off <= 1'b1;
      strt_cal   <= 1'b0;
      send_resp  <= 1'b0;
      resp       <= 8'h00;
    end else begin
      state     <= nxt;
      strt_cal  <= cal_go;
      send_resp <= rsp_vld;
      if (rsp_vld) resp <= rsp_val;
      if (mo_set)      motors_off <= 1'b1;
      else if (mo_clr) motors_off <= 1'b0;
    end

  assign busy         = (state != IDLE);
  assign inertial_cal = (state == CAL_WAIT) || (state == CAL_CHK);
endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Bench for cmd_cfg_mc (FAST_SIM=1, NUM_SP=3): vector table plus calibration/landing sequences,
// responses checked through an expected-response queue.
module tb_cmd_cfg_mc;
  localparam logic [7:0] ACK = 8'hA5, NACK = 8'hEE;

  logic clk = 1'b0, rst = 1'b1;
  logic cmd_rdy = 1'b0, cal_done = 1'b0;
  logic [7:0] cmd = '0;
  logic [15:0] data = '0;
  logic clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off, busy;
  logic [7:0] resp;
  logic [47:0] sp;
  logic [8:0] thrst;

  cmd_cfg_mc #(.NUM_SP(3), .SP_W(16), .THR_W(9), .FAST_SIM(1), .RAMP_STEP(4)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data), .cal_done(cal_done),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp), .sp(sp), .thrst(thrst),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal), .motors_off(motors_off), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && send_resp) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL resp_unexpected got=%0h want=none t=%0t", resp, $time);
      end else chk("resp", resp, exp_q.pop_front());
    end

  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, input bit has_rsp,
                          input logic [7:0] er);
    @(negedge clk);
    cmd_rdy = 1'b1; cmd = c; data = d;
    #1 chk($sformatf("clr_cmd_rdy_%0h", c), clr_cmd_rdy, 1);
    if (has_rsp) exp_q.push_back(er);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    chk($sformatf("send_resp_lat_%0h", c), send_resp, has_rsp);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  rsp;
    logic [47:0] sp;
    logic [8:0]  thr;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int got, n_end;
    tbl[0]  = '{8'h02, 16'h1234, ACK,  48'h0000_0000_1234, 9'h000};
    tbl[1]  = '{8'h03, 16'hABCD, ACK,  48'h0000_ABCD_1234, 9'h000};
    tbl[2]  = '{8'h04, 16'h5A5A, ACK,  48'h5A5A_ABCD_1234, 9'h000};
    tbl[3]  = '{8'h05, 16'h0123, ACK,  48'h5A5A_ABCD_1234, 9'h123};
    tbl[4]  = '{8'h3F, 16'hFFFF, NACK, 48'h5A5A_ABCD_1234, 9'h123};
    tbl[5]  = '{8'h01, 16'h0000, NACK, 48'h5A5A_ABCD_1234, 9'h123};
    tbl[6]  = '{8'h09, 16'h1111, NACK, 48'h5A5A_ABCD_1234, 9'h123};
    tbl[7]  = '{8'h05, 16'hFFFF, ACK,  48'h5A5A_ABCD_1234, 9'h1FF};
    tbl[8]  = '{8'h02, 16'h0000, ACK,  48'h5A5A_ABCD_0000, 9'h1FF};
    tbl[9]  = '{8'h08, 16'h0000, ACK,  48'h5A5A_ABCD_0000, 9'h1FF};
    tbl[10] = '{8'h05, 16'hFE0A, ACK,  48'h5A5A_ABCD_0000, 9'h00A};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sp", sp, 0);          chk("rst_thrst", thrst, 0);
    chk("rst_mo", motors_off, 1);  chk("rst_resp", resp, 8'h00);
    chk("rst_send", send_resp, 0); chk("rst_busy", busy, 0);
    chk("rst_strt", strt_cal, 0);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 11; k++) begin
      send_cmd(tbl[k].cmd, tbl[k].data, 1'b1, tbl[k].rsp);
      chk($sformatf("v%0d_sp", k), sp, tbl[k].sp);
      chk($sformatf("v%0d_thr", k), thrst, tbl[k].thr);
      chk($sformatf("v%0d_busy", k), busy, 0);
    end
    chk("tbl_mo", motors_off, 1);

    // Calibration success with a setpoint command held off until IDLE
    send_cmd(8'h06, 16'h0, 1'b0, 8'h00);
    exp_q.push_back(ACK);
    exp_q.push_back(ACK);
    chk("cal_strt", strt_cal, 1); chk("cal_busy", busy, 1); chk("cal_inert", inertial_cal, 1);
    @(posedge clk); #1 chk("cal_strt_pulse", strt_cal, 0);
    got = 0;
    for (int i = 0; i < 3000 && got == 0; i++) begin
      @(negedge clk);
      if (i == 4) begin cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h7777; end
      if (i == 518) cal_done = 1'b1;
      #1;
      if (i == 300) chk("cal_inert_mid", inertial_cal, 1);
      if (cmd_rdy && clr_cmd_rdy) begin
        got = 1;
        chk("held_until_idle", busy, 0);
        chk("cal_mo_on", motors_off, 0);
      end
    end
    chk("held_accepted", got, 1);
    @(posedge clk); #1;
    cmd_rdy = 1'b0; cal_done = 1'b0;
    chk("held_sp0", sp, 48'h5A5A_ABCD_7777);

    // Emergency land ramp 10 -> 6 -> 2 -> 0 -> motors off
    send_cmd(8'h07, 16'h0, 1'b1, ACK);
    chk("land_sp0", sp, 0); chk("land_busy", busy, 1); chk("land_thr0", thrst, 10);
    n_end = 0;
    for (int n = 1; n <= 2200; n++) begin
      @(posedge clk); #1;
      case (n)
        511:  chk("ramp_511", thrst, 10);
        512:  chk("ramp_512", thrst, 6);
        1024: chk("ramp_1024", thrst, 2);
        1536: chk("ramp_1536", thrst, 0);
        2047: chk("ramp_mo_2047", motors_off, 0);
        2048: chk("ramp_mo_2048", motors_off, 1);
        default: ;
      endcase
      if (!busy) begin n_end = n; break; end
    end
    chk("land_len", n_end, 2048);

    // Landing: other opcode NACKed but consumed, motors-off aborts
    send_cmd(8'h05, 16'h0050, 1'b1, ACK);
    send_cmd(8'h07, 16'h0, 1'b1, ACK);
    send_cmd(8'h02, 16'h9999, 1'b1, NACK);
    chk("land_nack_sp", sp, 0); chk("land_nack_busy", busy, 1);
    chk("land_nack_thr", thrst, 9'h050);
    send_cmd(8'h08, 16'h0, 1'b1, ACK);
    chk("abort_thr", thrst, 0); chk("abort_busy", busy, 0); chk("abort_mo", motors_off, 1);

    // Landing with zero thrust ends at the first tick
    send_cmd(8'h07, 16'h0, 1'b1, ACK);
    n_end = 0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk); #1;
      if (!busy) begin n_end = n; break; end
    end
    chk("land0_len", n_end, 512);

    // Calibration timeout
    send_cmd(8'h06, 16'h0, 1'b0, 8'h00);
    exp_q.push_back(NACK);
    n_end = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (!busy) begin n_end = n; break; end
    end
    chk("cal_to_len", n_end, 1024);
    chk("cal_to_mo", motors_off, 1);
    @(posedge clk); #1;

    // Reset in the middle of calibration
    send_cmd(8'h03, 16'h4242, 1'b1, ACK);
    send_cmd(8'h05, 16'h00AB, 1'b1, ACK);
    send_cmd(8'h06, 16'h0, 1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_strt", strt_cal, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_inert", inertial_cal, 0); chk("mid_rst_thr", thrst, 0);
    chk("mid_rst_sp", sp, 0); chk("mid_rst_resp", resp, 8'h00);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("resp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end
endmodule
